// File: rtl/iq_polyphase_interpolator_pkg.sv
// Shared types and helpers for the I/Q polyphase interpolator: FSM encoding,
// accumulator sizing and the built-in coefficient table.
package iq_polyphase_interpolator_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Full-precision accumulator: one product plus growth for TPP additions.
  function automatic int acc_width(input int width, input int coef_w, input int tpp);
    return width + coef_w + $clog2(tpp);
  endfunction

  // Built-in prototype filter, indexed as h[k*L+p]. For L=2/TPP=8/Q14 it is a
  // half-band style table: phase 0 is a pure delay, phase 1 a 8-tap interpolator.
  // Other geometries fall back to a linear-interpolation kernel. Every phase
  // sums to unity gain (2**frac).
  function automatic int default_coef(input int idx, input int l, input int tpp,
                                      input int frac);
    int k;
    int p;
    int c;
    if (l == 2 && tpp == 8 && frac == 14) begin
      case (idx)
        1, 15:   return -128;
        3, 13:   return 512;
        5, 11:   return -1536;
        6:       return 16384;
        7, 9:    return 9344;
        default: return 0;
      endcase
    end
    k = idx / l;
    p = idx % l;
    c = (tpp > 1) ? (tpp / 2 - 1) : 0;
    if (k == c) return ((l - p) << frac) / l;
    if (k == c + 1) return (p << frac) / l;
    return 0;
  endfunction

endpackage

// File: rtl/iq_polyphase_interpolator_coef_rom.sv
// Combinational phase -> TPP coefficient lookup, shared by the I and Q datapaths.
module iq_polyphase_interpolator_coef_rom
  import iq_polyphase_interpolator_pkg::*;
#(
  parameter int L             = 2,
  parameter int TPP           = 8,
  parameter int COEF_W        = 16,
  parameter int COEF_FRAC     = 14,
  parameter int COEF_GAIN_NUM = 1,
  parameter int COEF_GAIN_DEN = 1
) (
  input  logic        [2:0]        phase,
  output logic signed [COEF_W-1:0] coef [TPP]
);

  logic signed [COEF_W-1:0] table_lut [TPP][L];

  // The optional rational gain scales the whole built-in table; the caller keeps it within COEF_W.
  for (genvar gi = 0; gi < TPP; gi++) begin : g_tap
    for (genvar gp = 0; gp < L; gp++) begin : g_phase
      assign table_lut[gi][gp] = COEF_W'(default_coef(gi * L + gp, L, TPP, COEF_FRAC)
                                         * COEF_GAIN_NUM / COEF_GAIN_DEN);
    end
  end

  always_comb begin
    for (int k = 0; k < TPP; k++) begin
      coef[k] = '0;
      for (int p = 0; p < L; p++) begin
        if (phase == 3'(p)) coef[k] = table_lut[k][p];
      end
    end
  end

endmodule

// File: rtl/iq_polyphase_interpolator.sv
// I/Q upsampler by L: polyphase FIR or zero-order hold, 3-stage MAC pipeline,
// round-half-up, saturation with overflow flag, ready/valid input.
module iq_polyphase_interpolator
  import iq_polyphase_interpolator_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int L             = 2,
  parameter int TPP           = 8,
  parameter int COEF_W        = 16,
  parameter int COEF_FRAC     = 14,
  parameter int COEF_GAIN_NUM = 1,
  parameter int COEF_GAIN_DEN = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic signed [WIDTH-1:0] in_q,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic                    bypass,
  output logic signed [WIDTH-1:0] out_i,
  output logic signed [WIDTH-1:0] out_q,
  output logic                    out_vld,
  output logic        [2:0]       out_phase,
  output logic                    ovf
);

  localparam int ACC_W  = acc_width(WIDTH, COEF_W, TPP);
  localparam int PROD_W = WIDTH + COEF_W;
  localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  state_t     state_reg;
  logic [2:0] phase_reg;
  logic       bypass_reg;
  logic       last_phase;
  logic       accept;

  assign last_phase = (state_reg == ST_EMIT) && (phase_reg == 3'(L - 1));
  assign in_rdy     = !rst && ((state_reg == ST_IDLE) || last_phase);
  assign accept     = in_vld && in_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      phase_reg  <= '0;
      bypass_reg <= 1'b0;
    end else if (accept) begin
      state_reg  <= ST_EMIT;
      phase_reg  <= '0;
      bypass_reg <= bypass;
    end else if (state_reg == ST_EMIT) begin
      if (last_phase) state_reg <= ST_IDLE;
      else            phase_reg <= phase_reg + 3'd1;
    end
  end

  logic signed [COEF_W-1:0] coef [TPP];

  iq_polyphase_interpolator_coef_rom #(
    .L             (L),
    .TPP           (TPP),
    .COEF_W        (COEF_W),
    .COEF_FRAC     (COEF_FRAC),
    .COEF_GAIN_NUM (COEF_GAIN_NUM),
    .COEF_GAIN_DEN (COEF_GAIN_DEN)
  ) u_coef_rom (
    .phase (phase_reg),
    .coef  (coef)
  );

  logic       vld_s1_reg, vld_s2_reg, vld_s3_reg;
  logic [2:0] ph_s1_reg, ph_s2_reg, ph_s3_reg;
  logic       ovf_reg;
  logic [1:0] sat_ch;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_s1_reg <= 1'b0;
      vld_s2_reg <= 1'b0;
      vld_s3_reg <= 1'b0;
      ph_s1_reg  <= '0;
      ph_s2_reg  <= '0;
      ph_s3_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      vld_s1_reg <= (state_reg == ST_EMIT);
      ph_s1_reg  <= phase_reg;
      vld_s2_reg <= vld_s1_reg;
      ph_s2_reg  <= ph_s1_reg;
      vld_s3_reg <= vld_s2_reg;
      ovf_reg    <= vld_s2_reg && (|sat_ch);
      if (vld_s2_reg) ph_s3_reg <= ph_s2_reg;
    end
  end

  logic signed [WIDTH-1:0] in_ch [2];
  assign in_ch[0] = in_i;
  assign in_ch[1] = in_q;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    logic signed [WIDTH-1:0]  taps_reg [TPP];
    logic signed [PROD_W-1:0] prod_reg [TPP];
    logic signed [ACC_W-1:0]  sum_next;
    logic signed [ACC_W-1:0]  sum_reg;
    logic signed [ACC_W-1:0]  rnd;
    logic                     sat_hi;
    logic                     sat_lo;
    logic signed [WIDTH-1:0]  out_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < TPP; k++) taps_reg[k] <= '0;
      end else if (accept) begin
        taps_reg[0] <= in_ch[gi];
        for (int k = 1; k < TPP; k++) taps_reg[k] <= taps_reg[k-1];
      end
    end

    // Hold mode reuses the MAC: the newest sample at unity gain gives exactly x[n] after rounding.
    always_ff @(posedge clk) begin
      for (int k = 0; k < TPP; k++) begin
        if (!bypass_reg)
          prod_reg[k] <= PROD_W'(taps_reg[k]) * PROD_W'(coef[k]);
        else if (k == 0)
          prod_reg[k] <= PROD_W'(taps_reg[0]) <<< COEF_FRAC;
        else
          prod_reg[k] <= '0;
      end
    end

    always_comb begin
      sum_next = '0;
      for (int k = 0; k < TPP; k++) sum_next = sum_next + ACC_W'(prod_reg[k]);
    end

    always_ff @(posedge clk) begin
      sum_reg <= sum_next;
    end

    always_comb begin
      rnd    = (sum_reg + ROUND_K) >>> COEF_FRAC;
      sat_hi = (rnd > SAT_MAX);
      sat_lo = (rnd < SAT_MIN);
    end

    assign sat_ch[gi] = sat_hi | sat_lo;

    always_ff @(posedge clk) begin
      if (rst)             out_reg <= '0;
      else if (vld_s2_reg) begin
        if (sat_hi)      out_reg <= SAT_MAX[WIDTH-1:0];
        else if (sat_lo) out_reg <= SAT_MIN[WIDTH-1:0];
        else             out_reg <= rnd[WIDTH-1:0];
      end
    end
  end

  assign out_i     = g_ch[0].out_reg;
  assign out_q     = g_ch[1].out_reg;
  assign out_vld   = vld_s3_reg;
  assign out_phase = ph_s3_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_iq_polyphase_interpolator.sv
// Self-checking bench: randomized and directed stimulus against a plain
// arithmetic model of the L=2 / TPP=8 interpolator (unity and x1.5 tables).
module tb_iq_polyphase_interpolator;

  localparam int L   = 2;
  localparam int TPP = 8;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic [2:0]         ph;
    logic               ovf;
    int                 cyc;
  } obs_t;

  int h_tab  [16] = '{0, -128, 0, 512, 0, -1536, 16384, 9344, 0, 9344, 0, -1536, 0, 512, 0, -128};
  int hs_tab [16] = '{0, -192, 0, 768, 0, -2304, 24576, 14016, 0, 14016, 0, -2304, 0, 768, 0, -192};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] in_i = '0;
  logic signed [15:0] in_q = '0;
  logic in_vld = 1'b0;
  logic bypass = 1'b0;
  logic in_rdy, out_vld, ovf;
  logic signed [15:0] out_i, out_q;
  logic [2:0] out_phase;
  logic s_in_rdy, s_out_vld, s_ovf;
  logic signed [15:0] s_out_i, s_out_q;
  logic [2:0] s_out_phase;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int   hist_i[$];
  int   hist_q[$];
  obs_t cap[$];
  obs_t scap[$];
  obs_t exp_q[$];
  obs_t sexp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iq_polyphase_interpolator dut (
    .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q), .in_vld(in_vld), .in_rdy(in_rdy),
    .bypass(bypass), .out_i(out_i), .out_q(out_q), .out_vld(out_vld),
    .out_phase(out_phase), .ovf(ovf)
  );

  iq_polyphase_interpolator #(.COEF_GAIN_NUM(3), .COEF_GAIN_DEN(2)) dut_sat (
    .clk(clk), .rst(rst), .in_i(in_i), .in_q(in_q), .in_vld(in_vld), .in_rdy(s_in_rdy),
    .bypass(bypass), .out_i(s_out_i), .out_q(s_out_q), .out_vld(s_out_vld),
    .out_phase(s_out_phase), .ovf(s_ovf)
  );

  obs_t mon_o;
  obs_t mon_s;
  always @(negedge clk) begin
    if (out_vld === 1'b1) begin
      mon_o.i = out_i; mon_o.q = out_q; mon_o.ph = out_phase; mon_o.ovf = ovf; mon_o.cyc = cyc;
      cap.push_back(mon_o);
    end
    if (s_out_vld === 1'b1) begin
      mon_s.i = s_out_i; mon_s.q = s_out_q; mon_s.ph = s_out_phase; mon_s.ovf = s_ovf; mon_s.cyc = cyc;
      scap.push_back(mon_s);
    end
  end

  function automatic string fmt(input obs_t o);
    return $sformatf("i=%0d q=%0d ph=%0d ovf=%0d cyc=%0d", o.i, o.q, o.ph, o.ovf, o.cyc);
  endfunction

  // Expected output for phase p of the newest accepted pair, from the filter equation.
  function automatic obs_t model_out(input int p, input int a, input bit byp, input bit boost);
    obs_t  e;
    longint acc_i = 0;
    longint acc_q = 0;
    longint yi, yq;
    bit oi, oq;
    int c;
    e.ph  = 3'(p);
    e.cyc = a + 3 + p;
    if (byp) begin
      e.i = 16'(hist_i[0]); e.q = 16'(hist_q[0]); e.ovf = 1'b0;
      return e;
    end
    for (int k = 0; k < TPP && k < hist_i.size(); k++) begin
      c = boost ? hs_tab[k*L+p] : h_tab[k*L+p];
      acc_i += longint'(c) * hist_i[k];
      acc_q += longint'(c) * hist_q[k];
    end
    yi = (acc_i + 8192) >>> 14;
    yq = (acc_q + 8192) >>> 14;
    oi = (yi > 32767) || (yi < -32768);
    oq = (yq > 32767) || (yq < -32768);
    yi = (yi > 32767) ? 32767 : ((yi < -32768) ? -32768 : yi);
    yq = (yq > 32767) ? 32767 : ((yq < -32768) ? -32768 : yq);
    e.i = 16'(yi); e.q = 16'(yq); e.ovf = oi | oq;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic send(input int vi, input int vq, input bit byp);
    int waited = 0;
    in_i = 16'(vi); in_q = 16'(vq); bypass = byp; in_vld = 1'b1;
    @(negedge clk);
    while (in_rdy !== 1'b1) begin
      waited++;
      if (waited > 20) begin
        checks++; failures++;
        $display("FAIL send_timeout in_rdy=%b required=1 within 20 cycles", in_rdy);
        in_vld = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    hist_i.push_front(vi);
    hist_q.push_front(vq);
    for (int p = 0; p < L; p++) begin
      exp_q.push_back(model_out(p, cyc, byp, 1'b0));
      sexp_q.push_back(model_out(p, cyc, byp, 1'b1));
    end
    $display("accept cyc=%0d i=%0d q=%0d bypass=%0d", cyc, vi, vq, byp);
  endtask

  task automatic drain_and_clear();
    repeat (10) @(posedge clk);
    #1;
    cap.delete(); scap.delete(); exp_q.delete(); sexp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy got=%b want=0", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_out_vld got=%b want=0", out_vld); end
    checks++; if (out_i !== 16'sd0 || out_q !== 16'sd0) begin failures++; $display("FAIL reset_out_iq got=%0d/%0d want=0/0", out_i, out_q); end
    checks++; if (out_phase !== 3'd0 || ovf !== 1'b0) begin failures++; $display("FAIL reset_phase_ovf got=%0d/%b want=0/0", out_phase, ovf); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b1 || s_in_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_rdy got=%b/%b want=1/1", in_rdy, s_in_rdy); end
    checks++; if (out_vld !== 1'b0) begin failures++; $display("FAIL reset_release_vld got=%b want=0", out_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_impulse(input string name);
    drain_and_clear();
    send(16384, 0, 1'b0);
    for (int n = 1; n < TPP; n++) send(0, 0, 1'b0);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (cap.size() != exp_q.size()) begin failures++; $display("FAIL %s_count got=%0d want=%0d", name, cap.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== exp_q[j]) begin failures++; $display("FAIL %s[%0d] got %s want %s", name, j, fmt(cap[j]), fmt(exp_q[j])); end
    end
    for (int j = 0; j < 2 * TPP && j < cap.size(); j++) begin
      checks++;
      if (int'(cap[j].i) != h_tab[j] || cap[j].q !== 16'sd0) begin
        failures++; $display("FAIL %s_tap[%0d] got i=%0d q=%0d want i=%0d q=0", name, j, cap[j].i, cap[j].q, h_tab[j]);
      end
    end
  endtask

  task automatic test_dc();
    drain_and_clear();
    for (int n = 0; n < 2 * TPP + 2; n++) send(1000, -1000, 1'b0);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (cap.size() != exp_q.size()) begin failures++; $display("FAIL dc_count got=%0d want=%0d", cap.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== exp_q[j]) begin failures++; $display("FAIL dc[%0d] got %s want %s", j, fmt(cap[j]), fmt(exp_q[j])); end
    end
    for (int j = cap.size() - 2 * L; j >= 0 && j < cap.size(); j++) begin
      checks++;
      if (cap[j].i < 999 || cap[j].i > 1001 || cap[j].q < -1001 || cap[j].q > -999 || cap[j].ovf !== 1'b0) begin
        failures++; $display("FAIL dc_steady[%0d] got %s want i=1000 q=-1000 ovf=0", j, fmt(cap[j]));
      end
    end
  endtask

  task automatic test_saturation();
    drain_and_clear();
    for (int n = 0; n < TPP + 2; n++) send(32767, 0, 1'b0);
    repeat (6) @(posedge clk); #1;
    checks++;
    if (scap.size() == 0 || scap[scap.size()-1].i !== 16'sd32767 || scap[scap.size()-1].ovf !== 1'b1) begin
      failures++; $display("FAIL sat_pos got %s want i=32767 ovf=1", scap.size() ? fmt(scap[scap.size()-1]) : "none");
    end
    for (int n = 0; n < TPP + 2; n++) send(-32768, 0, 1'b0);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (scap.size() == 0 || scap[scap.size()-1].i !== -16'sd32768 || scap[scap.size()-1].ovf !== 1'b1) begin
      failures++; $display("FAIL sat_neg got %s want i=-32768 ovf=1", scap.size() ? fmt(scap[scap.size()-1]) : "none");
    end
    checks++;
    if (scap.size() != sexp_q.size() || cap.size() != exp_q.size()) begin
      failures++; $display("FAIL sat_count got=%0d/%0d want=%0d/%0d", scap.size(), cap.size(), sexp_q.size(), exp_q.size());
    end
    for (int j = 0; j < sexp_q.size() && j < scap.size(); j++) begin
      checks++;
      if (scap[j] !== sexp_q[j]) begin failures++; $display("FAIL sat_boost[%0d] got %s want %s", j, fmt(scap[j]), fmt(sexp_q[j])); end
    end
    for (int j = 0; j < exp_q.size() && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== exp_q[j]) begin failures++; $display("FAIL sat_unity[%0d] got %s want %s", j, fmt(cap[j]), fmt(exp_q[j])); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    drain_and_clear();
    for (int n = 0; n < 12; n++) begin
      send(int'($signed(16'($urandom))) / 4, int'($signed(16'($urandom))) / 4, 1'b0);
      acc_cyc.push_back(cyc);
    end
    repeat (10) @(posedge clk); #1;
    for (int n = 1; n < acc_cyc.size(); n++) begin
      checks++;
      if (acc_cyc[n] - acc_cyc[n-1] != L) begin failures++; $display("FAIL b2b_accept_gap[%0d] got=%0d want=%0d", n, acc_cyc[n] - acc_cyc[n-1], L); end
    end
    checks++;
    if (cap.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", cap.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== exp_q[j]) begin failures++; $display("FAIL b2b[%0d] got %s want %s", j, fmt(cap[j]), fmt(exp_q[j])); end
    end
  endtask

  task automatic test_bypass();
    drain_and_clear();
    send(5, -3, 1'b1);
    send(-7, 9, 1'b1);
    send(100, -100, 1'b0);
    send(3, 4, 1'b1);
    send(-2, 2, 1'b0);
    repeat (10) @(posedge clk); #1;
    checks++;
    if (cap.size() < 4 || cap[0].i !== 16'sd5 || cap[1].i !== 16'sd5 || cap[2].i !== -16'sd7 || cap[3].i !== -16'sd7) begin
      failures++; $display("FAIL bypass_zoh got=%0d,%0d,%0d,%0d want=5,5,-7,-7",
                           cap.size() > 0 ? cap[0].i : 0, cap.size() > 1 ? cap[1].i : 0,
                           cap.size() > 2 ? cap[2].i : 0, cap.size() > 3 ? cap[3].i : 0);
    end
    checks++;
    if (cap.size() != exp_q.size()) begin failures++; $display("FAIL bypass_count got=%0d want=%0d", cap.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== exp_q[j]) begin failures++; $display("FAIL bypass[%0d] got %s want %s", j, fmt(cap[j]), fmt(exp_q[j])); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int strobes = 0;
    drain_and_clear();
    send(16384, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    hist_i.delete(); hist_q.delete(); exp_q.delete(); sexp_q.delete();
    repeat (10) begin
      @(negedge clk);
      if (out_vld !== 1'b0 || s_out_vld !== 1'b0) strobes++;
    end
    checks++; if (strobes != 0) begin failures++; $display("FAIL midrst_strobes got=%0d want=0", strobes); end
    checks++; if (out_i !== 16'sd0 || out_q !== 16'sd0 || ovf !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=%0d/%0d/%b want=0/0/0", out_i, out_q, ovf); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL midrst_rdy got=%b want=1", in_rdy); end
    @(posedge clk); #1;
    test_impulse("impulse_rerun");
  endtask

  task automatic test_random();
    int gap;
    drain_and_clear();
    for (int n = 0; n < 40; n++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
      send(int'($signed(16'($urandom))), int'($signed(16'($urandom))), 1'($urandom_range(0, 3) == 0));
    end
    repeat (10) @(posedge clk); #1;
    checks++;
    if (cap.size() != exp_q.size() || scap.size() != sexp_q.size()) begin
      failures++; $display("FAIL random_count got=%0d/%0d want=%0d/%0d", cap.size(), scap.size(), exp_q.size(), sexp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < cap.size(); j++) begin
      checks++;
      if (cap[j] !== exp_q[j]) begin failures++; $display("FAIL random[%0d] got %s want %s", j, fmt(cap[j]), fmt(exp_q[j])); end
    end
    for (int j = 0; j < sexp_q.size() && j < scap.size(); j++) begin
      checks++;
      if (scap[j] !== sexp_q[j]) begin failures++; $display("FAIL random_boost[%0d] got %s want %s", j, fmt(scap[j]), fmt(sexp_q[j])); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_impulse("impulse");
    test_dc();
    test_saturation();
    test_back_to_back();
    test_bypass();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
